// File: rtl/load_store_unit.sv
// Load/store unit between EX and a byte-addressed data memory with a one-cycle registered read.
// Optional alignment trap: define MISALIGN_TRAP_EN to reject misaligned half/word/double accesses.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned XLEN      = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      mem_type,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]      state, state_nxt;
  logic            wr_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      size_c;
  logic [XLEN:0]   end_c;
  logic            req_ok_c;
  logic [XLEN-1:0] ext_c;

  // Request legality; the end address carries one extra bit so wrap-around past 2^XLEN is caught.
  always_comb begin
    size_c   = 4'd1 << req_funct3[1:0];
    end_c    = {1'b0, req_addr} + (XLEN+1)'(size_c);
    req_ok_c = 1'b1;
    if (req_write && req_funct3[2])
      req_ok_c = 1'b0;
    if (!req_write && (req_funct3 == 3'b111))
      req_ok_c = 1'b0;
    if (end_c > (XLEN+1)'(MEM_BYTES))
      req_ok_c = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if ((req_addr[2:0] & 3'(size_c - 4'd1)) != 3'b000)
      req_ok_c = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_valid) state_nxt = req_ok_c ? S_ISSUE : S_RESP;
      S_ISSUE:   state_nxt = wr_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP:    if (resp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Handshake and memory strobes decode only the state register, so reset drops them at once.
  assign req_ready      = (state == S_IDLE);
  assign resp_valid     = (state == S_RESP);
  assign mem_read       = (state == S_ISSUE) && !wr_q;
  assign mem_write      = (state == S_ISSUE) && wr_q;
  assign mem_type       = f3_q[1:0];
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

  // Load-data extension keyed on the latched funct3.
  always_comb begin
    ext_c = '0;
    case (f3_q)
      3'b000:  ext_c = {{(XLEN-8){mem_read_data[7]}},   mem_read_data[7:0]};
      3'b001:  ext_c = {{(XLEN-16){mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010:  ext_c = {{(XLEN-32){mem_read_data[31]}}, mem_read_data[31:0]};
      3'b011:  ext_c = mem_read_data;
      3'b100:  ext_c = {{(XLEN-8){1'b0}},  mem_read_data[7:0]};
      3'b101:  ext_c = {{(XLEN-16){1'b0}}, mem_read_data[15:0]};
      3'b110:  ext_c = {{(XLEN-32){1'b0}}, mem_read_data[31:0]};
      default: ext_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_data <= '0;
      resp_rd   <= 5'd0;
      resp_err  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && req_valid) begin
        wr_q      <= req_write;
        f3_q      <= req_funct3;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        resp_rd   <= req_rd;
        resp_err  <= !req_ok_c;
        resp_data <= '0;
      end
      if (state == S_CAPTURE)
        resp_data <= ext_c;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus randomized traffic vs a byte-array model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        mem_read, mem_write;
  logic [1:0]  mem_type;
  logic [63:0] mem_address, mem_write_data;
  logic [63:0] mem_read_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  logic [63:0] issue_addr = '0;
  logic [1:0]  issue_type = '0;

  logic [7:0] mem     [0:8191];
  logic [7:0] ref_mem [0:8191];

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, one-cycle registered zero-extended read.
  always @(posedge clk) begin
    logic [63:0] tmp;
    if (mem_write) begin
      wr_pulses  <= wr_pulses + 1;
      issue_addr <= mem_address;
      issue_type <= mem_type;
      for (int i = 0; i < (1 << mem_type); i++)
        mem[mem_address[12:0] + 13'(i)] = mem_write_data[8*i +: 8];
    end
    if (mem_read) begin
      rd_pulses  <= rd_pulses + 1;
      issue_addr <= mem_address;
      issue_type <= mem_type;
      tmp = '0;
      for (int i = 0; i < (1 << mem_type); i++)
        tmp[8*i +: 8] = mem[mem_address[12:0] + 13'(i)];
      mem_read_data <= tmp;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction; the model decides legality, data and latency from the architectural rules.
  task automatic do_txn(input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [4:0] rd, input int hold,
                        output logic [63:0] got_data, output logic got_err);
    logic        ok;
    int          size, lat, exp_lat, base_rd, base_wr;
    bit          seen;
    logic [63:0] exp_data;
    size = 1 << f3[1:0];
    ok = !(w && f3[2]) && !(!w && f3 == 3'b111) && (a <= 64'(8192 - size));
`ifdef MISALIGN_TRAP_EN
    if ((a % 64'(size)) != 64'd0) ok = 1'b0;
`endif
    exp_data = '0;
    if (ok && w)
      for (int i = 0; i < size; i++) ref_mem[int'(a[12:0]) + i] = wd[8*i +: 8];
    if (ok && !w) begin
      for (int i = 0; i < size; i++) exp_data[8*i +: 8] = ref_mem[int'(a[12:0]) + i];
      if (!f3[2] && size < 8 && exp_data[8*size-1])
        exp_data = exp_data | ~((64'd1 << (8*size)) - 64'd1);
    end
    exp_lat = !ok ? 1 : (w ? 2 : 3);

    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    base_rd = rd_pulses; base_wr = wr_pulses;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom}; req_rd = 5'($urandom);

    seen = 1'b0; lat = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; lat = c; end
      else chk("req_ready_busy", 64'(req_ready), 64'd0);
    end
    chk("resp_latency", 64'(lat), 64'(exp_lat));
    chk("resp_err", 64'(resp_err), 64'(!ok));
    chk("resp_data", resp_data, exp_data);
    chk("resp_rd", 64'(resp_rd), 64'(rd));
    got_data = resp_data; got_err = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_data", resp_data, exp_data);
      chk("hold_rd", 64'(resp_rd), 64'(rd));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_req_ready", 64'(req_ready), 64'd1);
    chk("post_resp_valid", 64'(resp_valid), 64'd0);
    chk("mem_read_pulses", 64'(rd_pulses - base_rd), 64'(ok && !w));
    chk("mem_write_pulses", 64'(wr_pulses - base_wr), 64'(ok && w));
    if (ok) begin
      chk("issue_addr", issue_addr, a);
      chk("issue_type", 64'(issue_type), 64'(f3[1:0]));
    end
  endtask

  initial begin
    logic [63:0] d, a;
    logic        e;
    logic [2:0]  f3;
    int          base;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Byte sign/zero extension
    do_txn(1'b1, 3'b000, 64'h10, 64'h80, 5'd1, 0, d, e);
    do_txn(1'b0, 3'b000, 64'h10, 64'h0, 5'd2, 0, d, e);
    chk("lb_value", d, 64'hFFFF_FFFF_FFFF_FF80);
    do_txn(1'b0, 3'b100, 64'h10, 64'h0, 5'd3, 0, d, e);
    chk("lbu_value", d, 64'h0000_0000_0000_0080);
    // Word sign/zero extension
    do_txn(1'b1, 3'b010, 64'h100, 64'h8000_0080, 5'd4, 0, d, e);
    do_txn(1'b0, 3'b010, 64'h100, 64'h0, 5'd5, 1, d, e);
    chk("lw_value", d, 64'hFFFF_FFFF_8000_0080);
    do_txn(1'b0, 3'b110, 64'h100, 64'h0, 5'd6, 0, d, e);
    chk("lwu_value", d, 64'h0000_0000_8000_0080);
    // Range boundary and wrap-around
    do_txn(1'b0, 3'b011, 64'h1FFC, 64'h0, 5'd8, 0, d, e);
    chk("ld_1ffc_err", 64'(e), 64'd1);
    do_txn(1'b0, 3'b011, 64'h1FF8, 64'h0, 5'd9, 0, d, e);
    chk("ld_1ff8_err", 64'(e), 64'd0);
    do_txn(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 5'd10, 0, d, e);
    chk("ld_wrap_err", 64'(e), 64'd1);
    // Illegal funct3
    do_txn(1'b0, 3'b111, 64'h40, 64'h0, 5'd11, 0, d, e);
    do_txn(1'b1, 3'b100, 64'h40, 64'h1234, 5'd12, 0, d, e);
    // Misaligned word
    do_txn(1'b0, 3'b010, 64'h102, 64'h0, 5'd13, 0, d, e);
`ifdef MISALIGN_TRAP_EN
    chk("lw_misalign_err", 64'(e), 64'd1);
`else
    chk("lw_misalign_err", 64'(e), 64'd0);
`endif
    // Back-pressure on the response
    do_txn(1'b0, 3'b011, 64'h100, 64'h0, 5'd7, 4, d, e);

    // Reset during store ISSUE must not write
    do_txn(1'b1, 3'b011, 64'h20, 64'h1122_3344_5566_7788, 5'd14, 0, d, e);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'h20; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_rd = 5'd15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("issue_mem_write", 64'(mem_write), 64'd1);
    base = wr_pulses;
    rst_n = 1'b0; #1;
    chk("arst_mem_write", 64'(mem_write), 64'd0);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    chk("arst_no_write", 64'(wr_pulses - base), 64'd0);
    do_txn(1'b0, 3'b011, 64'h20, 64'h0, 5'd16, 0, d, e);
    chk("ld_after_reset", d, 64'h1122_3344_5566_7788);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 64'($urandom_range(8176, 8191));
        1:       a = {$urandom, $urandom};
        2, 3:    a = 64'($urandom_range(0, 8191));
        default: a = 64'($urandom_range(0, 8191)) & ~((64'd1 << f3[1:0]) - 64'd1);
      endcase
      do_txn(1'($urandom), f3, a, {$urandom, $urandom}, 5'($urandom),
             int'($urandom_range(0, 2)), d, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the EX stage and the byte-addressed data memory, on the memory's request side.
- Accepts one load/store request at a time over a valid/ready handshake and decodes funct3 into the memory's 2-bit size code.
- Checks legality and range, sequences the memory's one-cycle registered read, and sign- or zero-extends load data.
- Returns one response per request to the writeback side over a second valid/ready handshake.

Parameters:
- MEM_BYTES, 8192: data memory size in bytes; accesses past this limit are errors.
- XLEN, 64: data and address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store data
- req_rd  in  5  destination register tag, returned with the response
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_data  out  XLEN  extended load result; 0 for stores and errors
- resp_rd  out  5  tag captured at accept
- resp_err  out  1  illegal funct3, out of range, or misaligned
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_type  out  2  size code: 00 byte, 01 half, 10 word, 11 double
- mem_address  out  XLEN  memory byte address
- mem_write_data  out  XLEN  memory store data
- mem_read_data  in  XLEN  memory read data, zero-extended, valid one cycle after mem_read

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state = IDLE.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready = 1. On req_valid at an edge, latch write, funct3, addr, wdata and rd.
  - Request legal: go to ISSUE.
  - Request illegal: go to RESP with resp_err = 1 and resp_data = 0; no memory access.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. 111 is illegal.
- Legal stores: funct3 000–011 only. 1xx is illegal.
- Range: addr + size > MEM_BYTES is illegal. Compute in 65 bits so wrap-around near 2^64 is caught as illegal.
- mem_type = funct3[1:0]. mem_address and mem_write_data come from the latched registers and are held for the whole transaction.
- mem_read and mem_write are decoded from the state register only, never from req_* inputs.
- ISSUE, one cycle: mem_read = 1 for a load or mem_write = 1 for a store.
  - Store: go to RESP.
  - Load: go to CAPTURE.
- CAPTURE, one cycle: sample mem_read_data and extend it into resp_data.
  - Signed ops extend from bit 7, 15 or 31; LD passes all 64 bits.
  - Unsigned ops zero-extend.
  - Go to RESP.
- RESP: resp_valid = 1. resp_data, resp_rd and resp_err stay stable until resp_valid && resp_ready at an edge, then go to IDLE.
- Latency from accept edge to first resp_valid cycle: load 3 cycles, store 2 cycles, error 1 cycle.
- No new request is accepted until the response handshake completes; req_ready is 0 in ISSUE, CAPTURE and RESP.
- Asynchronous reset in any state: immediately go to IDLE and drop mem_read, mem_write and resp_valid.
  - A store reset in ISSUE before the clock edge must not write.

Optional Feature:
- MISALIGN_TRAP_EN
- Defined: an access whose address is not a multiple of its size is illegal and returns resp_err = 1 with no memory access. Half needs addr[0] = 0, word addr[1:0] = 0, double addr[2:0] = 0.
- Undefined: no alignment check; misaligned accesses go to memory unchanged. Range and funct3 checks still apply.

Test Plan:
- SB 0x80 at addr 0x10, then LB 0x10 -> resp_data 0xFFFFFFFFFFFFFF80, resp_err 0; then LBU 0x10 -> 0x0000000000000080; load resp_valid exactly 3 cycles after accept.
- SW wdata 0x80000080 at 0x100, then LW 0x100 -> 0xFFFFFFFF80000080; LWU 0x100 -> 0x0000000080000080; store resp_valid exactly 2 cycles after accept.
- LD at 0x1FFC (8188) -> resp_err 1, resp_data 0, mem_read never asserted, resp_valid 1 cycle after accept; LD at 0x1FF8 -> resp_err 0.
- With MISALIGN_TRAP_EN: LW at 0x102 -> resp_err 1, no memory access. Without the macro: same request -> resp_err 0 and mem_read pulses once.
- Load to rd 7 with resp_ready held low 4 cycles -> resp_valid, resp_data and resp_rd = 7 stable throughout; req_ready stays 0; handshake on the 5th cycle returns to IDLE with req_ready = 1.
- rst_n pulled low during ISSUE of SD 0xFFFFFFFFFFFFFFFF at 0x20 -> mem_write drops immediately; a following LD 0x20 returns the pre-reset memory contents.
